// File: rtl/register_file.sv
// 32 x 32-bit RISC-V integer register file: synchronous write, combinational
// reads, x0 hardwired to zero, optional same-cycle write-through to the read ports.
module register_file #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDR_WIDTH    = 5,
  parameter logic [DATA_WIDTH-1:0] SP_INIT       = 32'h7FFF_EFFC,
  parameter logic [DATA_WIDTH-1:0] GP_INIT       = 32'h1000_8000,
  parameter int                    WRITE_THROUGH = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Reg_Write_i,
  input  logic [ADDR_WIDTH-1:0] Write_Register_i,
  input  logic [DATA_WIDTH-1:0] Write_Data_i,
  input  logic [ADDR_WIDTH-1:0] Read_Register_1_i,
  input  logic [ADDR_WIDTH-1:0] Read_Register_2_i,
  output logic [DATA_WIDTH-1:0] Read_Data_1_o,
  output logic [DATA_WIDTH-1:0] Read_Data_2_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [0:DEPTH-1];
  logic                  wr_en;
  logic                  bypass_1;
  logic                  bypass_2;

  // Writes aimed at x0 are discarded so its storage stays at the reset value of 0.
  assign wr_en = Reg_Write_i && (Write_Register_i != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      regs[2] <= SP_INIT;
      regs[3] <= GP_INIT;
    end else if (wr_en) begin
      regs[Write_Register_i] <= Write_Data_i;
    end
  end

  // Forwarding is disabled during reset: the write it would forward is dropped.
  assign bypass_1 = (WRITE_THROUGH != 0) && wr_en && !reset &&
                    (Read_Register_1_i == Write_Register_i);
  assign bypass_2 = (WRITE_THROUGH != 0) && wr_en && !reset &&
                    (Read_Register_2_i == Write_Register_i);

  assign Read_Data_1_o = (Read_Register_1_i == '0) ? '0 :
                         bypass_1                  ? Write_Data_i :
                                                     regs[Read_Register_1_i];

  assign Read_Data_2_o = (Read_Register_2_i == '0) ? '0 :
                         bypass_2                  ? Write_Data_i :
                                                     regs[Read_Register_2_i];

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: a write-through and a no-write-through instance share
// the stimulus and are compared against an array model of the architectural registers.
module tb_register_file;

  localparam logic [31:0] SP = 32'h7FFF_EFFC;
  localparam logic [31:0] GP = 32'h1000_8000;

  logic        clk;
  logic        reset;
  logic        reg_write;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [4:0]  rr1;
  logic [4:0]  rr2;
  logic [31:0] rd1_wt, rd2_wt, rd1_wo, rd2_wo;

  logic [31:0] model [0:31];
  int          n_asserts = 0;
  int          n_fail    = 0;

  register_file #(.WRITE_THROUGH(1)) dut_wt (
    .clk(clk), .reset(reset), .Reg_Write_i(reg_write),
    .Write_Register_i(wr_reg), .Write_Data_i(wr_data),
    .Read_Register_1_i(rr1), .Read_Register_2_i(rr2),
    .Read_Data_1_o(rd1_wt), .Read_Data_2_o(rd2_wt)
  );

  register_file #(.WRITE_THROUGH(0)) dut_wo (
    .clk(clk), .reset(reset), .Reg_Write_i(reg_write),
    .Write_Register_i(wr_reg), .Write_Data_i(wr_data),
    .Read_Register_1_i(rr1), .Read_Register_2_i(rr2),
    .Read_Data_1_o(rd1_wo), .Read_Data_2_o(rd2_wo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_asserts++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] idx, input bit wt);
    if (idx == 5'd0) return 32'h0;
    if (wt && reg_write && !reset && wr_reg != 5'd0 && idx == wr_reg) return wr_data;
    return model[idx];
  endfunction

  task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
    reset = r; reg_write = we; wr_reg = wa; wr_data = wd; rr1 = a1; rr2 = a2;
    #1;
  endtask

  task automatic check_ports(input string tag);
    check({tag, "_wt_rd1"}, rd1_wt, exp_read(rr1, 1'b1));
    check({tag, "_wt_rd2"}, rd2_wt, exp_read(rr2, 1'b1));
    check({tag, "_wo_rd1"}, rd1_wo, exp_read(rr1, 1'b0));
    check({tag, "_wo_rd2"}, rd2_wo, exp_read(rr2, 1'b0));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      model[2] = SP;
      model[3] = GP;
    end else if (reg_write && wr_reg != 5'd0) begin
      model[wr_reg] = wr_data;
    end
    #1;
  endtask

  initial begin
    logic [31:0] cexp;
    logic [4:0]  wa;

    // Two reset cycles; outputs are undefined until the first reset edge.
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd2, 5'd3);
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd2, 5'd3);
    check_ports("reset2");
    check("reset_sp_const", rd1_wt, SP);
    check("reset_gp_const", rd2_wo, GP);
    tick();

    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      check_ports("sweep");
      cexp = (i == 2) ? SP : (i == 3) ? GP : 32'h0;
      check("sweep_const", rd1_wt, cexp);
      tick();
    end

    drive(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd1, 5'd6);
    check_ports("wr_x5");
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    check_ports("rd_x5");
    check("x5_rd1_const", rd1_wo, 32'hDEAD_BEEF);
    check("x5_rd2_const", rd2_wt, 32'hDEAD_BEEF);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd6, 5'd5);
    check("x6_untouched", rd1_wt, 32'h0);
    tick();

    drive(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    check("x0_wr_cycle_wt", rd1_wt, 32'h0);
    check("x0_wr_cycle_wo", rd2_wo, 32'h0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    check("x0_after_edge", rd1_wt, 32'h0);
    check_ports("x0_after");
    tick();

    drive(1'b0, 1'b1, 5'd7, 32'h11, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b1, 5'd7, 32'h22, 5'd7, 5'd7);
    check("bypass_wt_rd2", rd2_wt, 32'h22);
    check("bypass_wt_rd1", rd1_wt, 32'h22);
    check("nobypass_wo_rd2", rd2_wo, 32'h11);
    check_ports("bypass");
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd7);
    check("x7_after_wt", rd2_wt, 32'h22);
    check("x7_after_wo", rd2_wo, 32'h22);
    tick();

    drive(1'b0, 1'b0, 5'd9, 32'h1234, 5'd9, 5'd9);
    check_ports("we0_x9");
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    check("x9_unchanged", rd1_wt, 32'h0);
    tick();

    drive(1'b0, 1'b1, 5'd10, 32'h55, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b1, 5'd10, 32'h99, 5'd10, 5'd2);
    check("rst_nobypass_pre", rd1_wt, 32'h55);
    check_ports("rst_wr_pre");
    tick();
    drive(1'b1, 1'b1, 5'd10, 32'h99, 5'd10, 5'd2);
    check("rst_nobypass_post", rd1_wt, 32'h0);
    check("rst_sp_post", rd2_wt, SP);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd2);
    check("x10_cleared", rd1_wo, 32'h0);
    check("x2_restored", rd2_wo, SP);
    tick();

    for (int n = 0; n < 400; n++) begin
      wa = 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 31) == 0), 1'($urandom), wa, $urandom,
            ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)));
      check_ports("rand");
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
